// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-cycle carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned GROUP = 4;

    // Legal geometry: whole chunks per operand, whole 4-bit groups per chunk.
    function automatic logic params_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (chunk % GROUP == 0) && (width >= chunk) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/cla_multicycle_adder_if.sv
// Operand/result handshake bundle between the reduction stage and the adder.
interface cla_multicycle_adder_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/cla_slice.sv
// CHUNK-bit combinational two-level carry-lookahead adder (4-bit groups).
module cla_slice
    import cla_pkg::*;
#(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb
);
    localparam int unsigned NG = CHUNK / GROUP;

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] c;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;

    // Sum-of-products carry into bit pos of one group: no ripple terms.
    function automatic logic carry_at(input logic [GROUP-1:0] gv, input logic [GROUP-1:0] pv,
                                      input logic ci, input int unsigned pos);
        logic acc;
        logic term;
        term = ci;
        for (int unsigned k = 0; k < pos; k++) term = term & pv[k];
        acc = term;
        for (int unsigned j = 0; j < pos; j++) begin
            term = gv[j];
            for (int unsigned k = j + 1; k < pos; k++) term = term & pv[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    assign p = a ^ b;
    assign g = a & b;

    // Per-group propagate/generate and bit carries from the group's lookahead carry-in.
    for (genvar gi = 0; gi < NG; gi++) begin : g_group
        logic [GROUP-1:0] pv;
        logic [GROUP-1:0] gv;
        assign pv     = p[gi*GROUP +: GROUP];
        assign gv     = g[gi*GROUP +: GROUP];
        assign gp[gi] = &pv;
        assign gg[gi] = carry_at(gv, pv, 1'b0, GROUP);
        for (genvar bi = 0; bi < GROUP; bi++) begin : g_bit
            assign c[gi*GROUP + bi] = carry_at(gv, pv, gc[gi], bi);
        end
    end

    // Second lookahead level: carry into each group straight from group P/G and c_in.
    always_comb begin
        logic acc;
        logic term;
        gc    = '0;
        gc[0] = c_in;
        for (int unsigned j = 1; j <= NG; j++) begin
            term = c_in;
            for (int unsigned k = 0; k < j; k++) term = term & gp[k];
            acc = term;
            for (int unsigned m = 0; m < j; m++) begin
                term = gg[m];
                for (int unsigned k = m + 1; k < j; k++) term = term & gp[k];
                acc = acc | term;
            end
            gc[j] = acc;
        end
    end

    assign s     = p ^ c;
    assign c_out = gc[NG];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_multicycle_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit lookahead slice per cycle, carry chained in a register.
module cla_multicycle_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_multicycle_adder_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("cla_multicycle_adder: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
    end

    state_t                       state;
    state_t                       state_next;
    logic [CW-1:0]                cnt;
    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_q;
    logic                         carry_q;
    logic                         c_out_q;
    logic                         ovf_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         accept;
    logic                         step;
    logic                         last;
    logic [CHUNK-1:0]             slice_s;
    logic                         slice_co;
    logic                         slice_msb;

    cla_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (a_q[cnt]),
        .b     (b_q[cnt]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_co),
        .c_msb (slice_msb)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(NCHUNK - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == IDLE);
            out_valid_q <= (state_next == DONE);
        end
    end

    // Operand capture, chunk-wise sum write-back and flag capture on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ^ bus.c_in;
            cnt     <= '0;
        end else if (step) begin
            sum_q[cnt] <= slice_s;
            carry_q    <= slice_co;
            cnt        <= cnt + CW'(1);
            if (last) begin
                c_out_q <= slice_co;
                ovf_q   <= slice_co ^ slice_msb;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Self-checking bench: directed cases on CHUNK=16, random sweep over CHUNK=16/4/64.
module tb_cla_multicycle_adder;

    localparam int unsigned WIDTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        c_in;
    logic        sub;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    int          sel;

    logic        in_ready;
    logic        out_valid;
    logic        c_out;
    logic        ovf;
    logic [63:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cla_multicycle_adder_if #(.WIDTH(WIDTH)) bus16 ();
    cla_multicycle_adder_if #(.WIDTH(WIDTH)) bus4 ();
    cla_multicycle_adder_if #(.WIDTH(WIDTH)) bus64 ();

    cla_multicycle_adder #(.WIDTH(WIDTH), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_multicycle_adder #(.WIDTH(WIDTH), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    cla_multicycle_adder #(.WIDTH(WIDTH), .CHUNK(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    assign bus16.in_valid  = in_valid && (sel == 0);
    assign bus4.in_valid   = in_valid && (sel == 1);
    assign bus64.in_valid  = in_valid && (sel == 2);
    assign bus16.out_ready = out_ready && (sel == 0);
    assign bus4.out_ready  = out_ready && (sel == 1);
    assign bus64.out_ready = out_ready && (sel == 2);
    assign bus16.a = a;    assign bus4.a = a;    assign bus64.a = a;
    assign bus16.b = b;    assign bus4.b = b;    assign bus64.b = b;
    assign bus16.c_in = c_in; assign bus4.c_in = c_in; assign bus64.c_in = c_in;
    assign bus16.sub = sub;   assign bus4.sub = sub;   assign bus64.sub = sub;

    assign in_ready  = (sel == 0) ? bus16.in_ready  : (sel == 1) ? bus4.in_ready  : bus64.in_ready;
    assign out_valid = (sel == 0) ? bus16.out_valid : (sel == 1) ? bus4.out_valid : bus64.out_valid;
    assign sum       = (sel == 0) ? bus16.sum       : (sel == 1) ? bus4.sum       : bus64.sum;
    assign c_out     = (sel == 0) ? bus16.c_out     : (sel == 1) ? bus4.c_out     : bus64.c_out;
    assign ovf       = (sel == 0) ? bus16.ovf       : (sel == 1) ? bus4.ovf       : bus64.ovf;

    // Reference: exact integer add/subtract; c_out = carry (add) or no-borrow (sub), ovf = result outside signed 64-bit range.
    function automatic logic [65:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                           input logic ci, input logic s);
        logic [64:0]        wide;
        logic signed [65:0] sx;
        logic signed [65:0] sy;
        logic signed [65:0] sc;
        logic signed [65:0] ideal;
        logic               co;
        logic               ov;
        sx = $signed({{2{x[63]}}, x});
        sy = $signed({{2{y[63]}}, y});
        sc = $signed({65'd0, ci});
        if (!s) begin
            wide  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            co    = wide[64];
            ideal = sx + sy + sc;
        end else begin
            wide  = {1'b0, x} - {1'b0, y} - {64'd0, ci};
            co    = ~wide[64];
            ideal = sx - sy - sc;
        end
        ov = !((ideal[65:63] == 3'b000) || (ideal[65:63] == 3'b111));
        return {co, ov, ideal[63:0]};
    endfunction

    // Present one operand bundle, wait for acceptance and for out_valid; leaves the DUT in DONE.
    task automatic do_op(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic s,
                         output int lat, output logic ok);
        int n;
        ok = 1'b1;
        lat = 0;
        a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++; ok = 1'b0;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (ok && !out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (ok && !out_valid) begin
            n_tests++; n_fail++; ok = 1'b0;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid, c_out, ovf} !== 4'b1000 || sum !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b c_out=%0b ovf=%0b sum=%h required 1 0 0 0 0",
                     in_ready, out_valid, c_out, ovf, sum);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Directed cases from fixed operands: carry chain, signed overflow, subtract both ways.
    task automatic test_directed();
        logic [63:0] xs [4];
        logic [63:0] ys [4];
        logic        ss [4];
        logic [63:0] es [4];
        logic        ec [4];
        logic        eo [4];
        int          lat;
        logic        ok;
        xs = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'd7};
        ys = '{64'd1, 64'd1, 64'd7, 64'd5};
        ss = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b0};
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            do_op(xs[i], ys[i], 1'b0, ss[i], lat, ok);
            if (ok) begin
                n_tests++;
                if (sum !== es[i] || c_out !== ec[i] || ovf !== eo[i]) begin
                    n_fail++;
                    $display("FAIL directed_%0d: sum=%h c_out=%0b ovf=%0b required sum=%h c_out=%0b ovf=%0b",
                             i, sum, c_out, ovf, es[i], ec[i], eo[i]);
                end
                n_tests++;
                if (lat != 4) begin
                    n_fail++;
                    $display("FAIL directed_latency_%0d: latency=%0d required 4", i, lat);
                end
            end
            release_out();
        end
    endtask

    // Held result under out_ready=0 with in_valid pulses that must be ignored.
    task automatic test_backpressure();
        logic [65:0] exp;
        int          lat;
        logic        ok;
        sel = 0;
        exp = ref_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, lat, ok);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0); a = 64'd99; b = 64'd1; c_in = 1'b0; sub = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {c_out, ovf, sum} !== exp) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: out_valid=%0b in_ready=%0b c_out=%0b ovf=%0b sum=%h required 1 0 %0b %0b %h",
                         i, out_valid, in_ready, c_out, ovf, sum, exp[65], exp[64], exp[63:0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_pulses: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    // Asynchronous reset at chunk 2 of 4, then a clean operation.
    task automatic test_reset_mid();
        int   lat;
        logic ok;
        sel = 0;
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (sum[31:0] !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL partial_sum: sum[31:0]=%h required fffffffe", sum[31:0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sum !== 64'd0 || c_out !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%0b sum=%h c_out=%0b ovf=%0b required 0 0 0 0",
                     out_valid, sum, c_out, ovf);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_%0d: out_valid=%0b in_ready=%0b required 0 1", i, out_valid, in_ready);
            end
        end
        do_op(64'd3, 64'd4, 1'b0, 1'b0, lat, ok);
        if (ok) begin
            n_tests++;
            if (sum !== 64'd7 || c_out !== 1'b0 || ovf !== 1'b0 || lat != 4) begin
                n_fail++;
                $display("FAIL after_reset_add: sum=%h c_out=%0b ovf=%0b latency=%0d required 7 0 0 4",
                         sum, c_out, ovf, lat);
            end
        end
        release_out();
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] r;
        case ($urandom_range(0, 7))
            0: r = 64'd0;
            1: r = 64'hFFFF_FFFF_FFFF_FFFF;
            2: r = 64'h8000_0000_0000_0000;
            3: r = 64'h7FFF_FFFF_FFFF_FFFF;
            default: r = {$urandom(), $urandom()};
        endcase
        return r;
    endfunction

    // Random operands, modes and output stalls on one of the three geometries.
    task automatic test_random(input int which, input int n_ops);
        int          chunk;
        int          lat;
        int          stall;
        logic        ok;
        logic [63:0] x;
        logic [63:0] y;
        logic        ci;
        logic        s;
        logic [65:0] exp;
        sel   = which;
        chunk = (which == 0) ? 16 : (which == 1) ? 4 : 64;
        for (int i = 0; i < n_ops; i++) begin
            x = pick_operand(); y = pick_operand();
            ci = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            exp = ref_op(x, y, ci, s);
            do_op(x, y, ci, s, lat, ok);
            if (ok) begin
                n_tests++;
                if ({c_out, ovf, sum} !== exp || lat != 64 / chunk) begin
                    n_fail++;
                    $display("FAIL random_c%0d_%0d: a=%h b=%h c_in=%0b sub=%0b sum=%h c_out=%0b ovf=%0b lat=%0d required %h %0b %0b %0d",
                             chunk, i, x, y, ci, s, sum, c_out, ovf, lat, exp[63:0], exp[65], exp[64], 64 / chunk);
                end
                stall = $urandom_range(0, 3);
                repeat (stall) begin
                    @(posedge clk); #1;
                end
                n_tests++;
                if (out_valid !== 1'b1 || {c_out, ovf, sum} !== exp) begin
                    n_fail++;
                    $display("FAIL random_hold_c%0d_%0d: out_valid=%0b sum=%h required 1 %h",
                             chunk, i, out_valid, sum, exp[63:0]);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(0, 200);
        test_random(1, 200);
        test_random(2, 200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
